// File: rtl/bcd3_countdown_pkg.sv
// Shared types and constants for the three-digit BCD countdown timer.
package bcd3_countdown_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Out-of-range preset digits saturate so the count never holds a non-BCD value.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/bcd3_countdown_digit.sv
// One BCD digit of the decrement chain: applies an incoming borrow and
// passes a borrow upward when the digit wraps from 0 to 9.
module bcd_digit_dec
    import bcd3_countdown_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] next_digit,
    output logic               borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == '0) begin
                next_digit = DIGIT_MAX;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd3_countdown.sv
// Three-digit BCD down-counter with preset register, start/enable control
// and optional automatic reload on reaching zero.
module bcd3_countdown
    import bcd3_countdown_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] PRE0,
    input  logic [DIGIT_W-1:0] PRE1,
    input  logic [DIGIT_W-1:0] PRE2,
    input  logic               start,
    input  logic               enable,
    output logic [DIGIT_W-1:0] BCD0,
    output logic [DIGIT_W-1:0] BCD1,
    output logic [DIGIT_W-1:0] BCD2,
    output logic               busy,
    output logic               done
);

    state_t             state;
    logic [DIGIT_W-1:0] pre0, pre1, pre2;
    logic [DIGIT_W-1:0] dec0, dec1, dec2;
    logic               borrow0, borrow1, borrow2;
    logic               count_zero;
    logic               dec_zero;

    bcd_digit_dec u_dig0 (.digit(BCD0), .borrow_in(1'b1),    .next_digit(dec0), .borrow_out(borrow0));
    bcd_digit_dec u_dig1 (.digit(BCD1), .borrow_in(borrow0), .next_digit(dec1), .borrow_out(borrow1));
    bcd_digit_dec u_dig2 (.digit(BCD2), .borrow_in(borrow1), .next_digit(dec2), .borrow_out(borrow2));

    // A borrow out of the hundreds digit can only happen when the count is 000.
    assign count_zero = borrow2;
    assign dec_zero   = (dec0 == '0) && (dec1 == '0) && (dec2 == '0);

    always_ff @(posedge clock) begin
        if (clear) begin
            BCD0  <= '0;
            BCD1  <= '0;
            BCD2  <= '0;
            pre0  <= '0;
            pre1  <= '0;
            pre2  <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            BCD0  <= clamp_digit(PRE0);
            BCD1  <= clamp_digit(PRE1);
            BCD2  <= clamp_digit(PRE2);
            pre0  <= clamp_digit(PRE0);
            pre1  <= clamp_digit(PRE1);
            pre2  <= clamp_digit(PRE2);
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // Starting from 000 terminates at once instead of wrapping to 999.
                    if (start) begin
                        if (count_zero) begin
                            done  <= 1'b1;
                            state <= AUTO_RELOAD ? RUN : DONE;
                            busy  <= AUTO_RELOAD;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (count_zero) begin
                            BCD0 <= pre0;
                            BCD1 <= pre1;
                            BCD2 <= pre2;
                        end else begin
                            BCD0 <= dec0;
                            BCD1 <= dec1;
                            BCD2 <= dec2;
                            if (dec_zero) begin
                                done <= 1'b1;
                                if (!AUTO_RELOAD) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd3_countdown.md
BCD3_COUNTDOWN -- requirements
Module: bcd3_countdown

Interface
REQ-001 Parameter AUTO_RELOAD, default 0: 1 = on reaching zero, reload the latched preset and keep running; 0 = stop in DONE.
REQ-002 clock  in  1  sole clock, all state updates on rising edge.
REQ-003 clear  in  1  synchronous active-high reset, sampled on rising edge of clock.
REQ-004 load  in  1  capture preset digits into the count and the preset register.
REQ-005 PRE0, PRE1, PRE2  in  4 each  preset BCD digits: ones, tens, hundreds.
REQ-006 start  in  1  begin countdown from the current count.
REQ-007 enable  in  1  count tick qualifier; one decrement per cycle with enable high while running.
REQ-008 BCD0, BCD1, BCD2  out  4 each  current count digits: ones, tens, hundreds.
REQ-009 busy  out  1  high while in RUN.
REQ-010 done  out  1  one-cycle pulse when the count reaches 000.

Function
REQ-011 FSM states: IDLE, RUN, DONE; encoding is implementation choice.
REQ-012 IDLE -> RUN on start=1; RUN -> DONE when a decrement yields 000 and AUTO_RELOAD=0; DONE -> RUN on start=1.
REQ-013 load=1 in any state: count <= preset, preset register <= PRE*, state <= IDLE next cycle; load beats start, enable and terminal count in the same cycle.
REQ-014 Preset digit >9 clamps to 9 on capture, per digit independently.
REQ-015 Decrement rule: BCD0 = 0 -> BCD0 <= 9 with a borrow into BCD1; BCD1 = 0 with borrow -> 9 with a borrow into BCD2; otherwise digit - 1. Only digits receiving a borrow change.
REQ-016 Count changes only in RUN with enable=1 and load=0; enable is ignored in IDLE and DONE.
REQ-017 Terminal: in RUN, enable=1 and count=001 -> count <= 000 and done=1 in the following cycle.
REQ-018 start in IDLE or DONE with count=000: done pulses on the next cycle, count stays 000, no wrap to 999; the FSM goes to DONE, or stays in RUN if AUTO_RELOAD=1.
REQ-019 AUTO_RELOAD=1: the decrement to 000 pulses done and loads the preset register into the count on the next enabled tick; the FSM stays in RUN.
REQ-020 start while in RUN is ignored.
REQ-021 done never exceeds one cycle per terminal event; busy = (state == RUN), registered.
REQ-022 Output latency: BCD* reflect the count register directly, valid the cycle after the update edge.

Reset
REQ-023 clear=1: BCD0=BCD1=BCD2=0, preset register = 0, state IDLE, busy=0, done=0 on the next edge.
REQ-024 clear overrides load, start and enable, including mid-countdown; an in-flight done is suppressed.
REQ-025 No asynchronous reset path; output values before the first clear edge are undefined.

Structure
REQ-026 Shared package holds the FSM state typedef, the BCD digit width constant (4) and the BCD max-digit constant (9).
REQ-027 One sub-module, bcd_digit_dec: a single BCD digit with borrow-in, produces the next digit and borrow-out; instantiated three times in a chain.
REQ-028 The preset register and FSM live in the top module; no other hierarchy.

Verification
REQ-029 clear; load PRE=1,0,0 (count 001); start; one enable -> count 000, done high exactly one cycle, busy low afterward, state DONE.
REQ-030 load count 100; start; one enable -> count 099; hold enable for 99 more cycles -> 000, done pulses once.
REQ-031 load PRE2=0xC, PRE1=0xA, PRE0=0x5 -> count 995; digits always remain 0..9 during a full countdown to 000.
REQ-032 AUTO_RELOAD=1, preset 003; start; enable held high -> sequence 002, 001, 000 (done), 003, 002, ...; busy stays high.
REQ-033 At count 500 in RUN: assert clear and load together -> count 000, IDLE, no done; then load and start in the same cycle -> load wins, state IDLE.
REQ-034 load count 000; start -> done pulses next cycle, count stays 000 (no wrap to 999).
